// File: rtl/prco_lmem_arbiter_if.sv
// Local-memory arbiter bus bundle.
// Groups the three requester ports (fetch F, data D, loader L), the shared
// status outputs (err/busy) and the single-port local-memory interface.
//   slave  : view taken by the arbiter (requests in, completions/memory strobes out)
//   master : view taken by the requesters and the memory model
interface prco_lmem_arbiter_if #(
  parameter int P_ADDR_W = 16
);
  // Fetch port (read-only)
  logic                i_f_req;
  logic [P_ADDR_W-1:0] i_f_addr;
  logic                q_f_done;
  logic [15:0]         q_f_rdata;
  // Data port (load/store)
  logic                i_d_req;
  logic                i_d_we;
  logic [P_ADDR_W-1:0] i_d_addr;
  logic [15:0]         i_d_wdata;
  logic                q_d_done;
  logic [15:0]         q_d_rdata;
  // Loader port (write-only)
  logic                i_l_req;
  logic [P_ADDR_W-1:0] i_l_addr;
  logic [15:0]         i_l_wdata;
  logic                q_l_done;
  // Status
  logic                q_err;
  logic                q_busy;
  // Local memory
  logic                q_mem_ce;
  logic                q_mem_we;
  logic [P_ADDR_W-1:0] q_mem_addr;
  logic [15:0]         q_mem_dina;
  logic [15:0]         i_mem_douta;

  modport slave (
    input  i_f_req, i_f_addr,
    output q_f_done, q_f_rdata,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata,
    output q_d_done, q_d_rdata,
    input  i_l_req, i_l_addr, i_l_wdata,
    output q_l_done,
    output q_err, q_busy,
    output q_mem_ce, q_mem_we, q_mem_addr, q_mem_dina,
    input  i_mem_douta
  );

  modport master (
    output i_f_req, i_f_addr,
    input  q_f_done, q_f_rdata,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata,
    input  q_d_done, q_d_rdata,
    output i_l_req, i_l_addr, i_l_wdata,
    input  q_l_done,
    input  q_err, q_busy,
    input  q_mem_ce, q_mem_we, q_mem_addr, q_mem_dina,
    output i_mem_douta
  );
endinterface

// File: rtl/prco_lmem_arbiter.sv
// Single-port local-memory arbiter/sequencer.
// Shares a 16-bit, 1-cycle synchronous-read memory between instruction fetch
// (F, read), the ALU data port (D, read/write) and the UART loader (L, write).
// One access at a time: IDLE -> ACCESS (memory strobe) -> RESP (done pulse).
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : prco_lmem_arbiter_if.slave (requester ports, err/busy, memory side)
module prco_lmem_arbiter #(
  parameter int P_LMEM_DEPTH = 256,
  parameter int P_ADDR_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  prco_lmem_arbiter_if.slave   bus
);

  localparam int                DATA_W  = 16;
  localparam logic [P_ADDR_W:0] DEPTH_X = (P_ADDR_W + 1)'(P_LMEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_F = 2'd0, OWN_D = 2'd1, OWN_L = 2'd2} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, gnt_owner;
  logic                we_q, oor_q;
  logic                rr_last_d_q;   // 1: last F/D grant went to D
  logic [P_ADDR_W-1:0] mem_addr_q, gnt_addr;
  logic [DATA_W-1:0]   mem_dina_q, gnt_wdata;
  logic [DATA_W-1:0]   f_rdata_q, d_rdata_q, rd_val;
  logic                arb_en, in_resp;
  logic                f_m, d_m, l_m;
  logic                gnt_f, gnt_d, gnt_l, gnt_any, gnt_we, gnt_oor;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_F;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      rr_last_d_q <= 1'b1;
      mem_addr_q  <= '0;
      mem_dina_q  <= '0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_any) begin
        owner_q <= gnt_owner;
        we_q    <= gnt_we;
        oor_q   <= gnt_oor;
        // Out-of-range requests never reach the memory pins, so the
        // address/data latches keep the last forwarded access.
        if (!gnt_oor) begin
          mem_addr_q <= gnt_addr;
          mem_dina_q <= gnt_wdata;
        end
      end
      if (gnt_f) rr_last_d_q <= 1'b0;
      if (gnt_d) rr_last_d_q <= 1'b1;
      if (in_resp && owner_q == OWN_F) f_rdata_q <= rd_val;
      if (in_resp && owner_q == OWN_D) d_rdata_q <= rd_val;
    end
  end

  always_comb begin
    in_resp = (state_q == S_RESP);
    arb_en  = (state_q == S_IDLE) || in_resp;
    // The owner in RESP still holds req during its done cycle; mask it so
    // the same request is not granted twice.
    f_m = bus.i_f_req & ~(in_resp & (owner_q == OWN_F));
    d_m = bus.i_d_req & ~(in_resp & (owner_q == OWN_D));
    l_m = bus.i_l_req & ~(in_resp & (owner_q == OWN_L));

    gnt_l   = arb_en & l_m;
    gnt_f   = arb_en & ~l_m & f_m & (~d_m | rr_last_d_q);
    gnt_d   = arb_en & ~l_m & d_m & (~f_m | ~rr_last_d_q);
    gnt_any = gnt_l | gnt_f | gnt_d;

    gnt_owner = OWN_F;
    gnt_addr  = bus.i_f_addr;
    gnt_wdata = mem_dina_q;
    gnt_we    = 1'b0;
    if (gnt_l) begin
      gnt_owner = OWN_L;
      gnt_addr  = bus.i_l_addr;
      gnt_wdata = bus.i_l_wdata;
      gnt_we    = 1'b1;
    end else if (gnt_d) begin
      gnt_owner = OWN_D;
      gnt_addr  = bus.i_d_addr;
      gnt_wdata = bus.i_d_wdata;
      gnt_we    = bus.i_d_we;
    end
    gnt_oor = ({1'b0, gnt_addr} >= DEPTH_X);

    state_d = state_q;
    case (state_q)
      S_IDLE, S_RESP: state_d = gnt_any ? (gnt_oor ? S_RESP : S_ACCESS) : S_IDLE;
      S_ACCESS:       state_d = S_RESP;
      default:        state_d = S_IDLE;
    endcase

    rd_val = (we_q | oor_q) ? '0 : bus.i_mem_douta;
  end

  assign bus.q_mem_ce   = (state_q == S_ACCESS);
  assign bus.q_mem_we   = (state_q == S_ACCESS) & we_q;
  assign bus.q_mem_addr = mem_addr_q;
  assign bus.q_mem_dina = mem_dina_q;
  assign bus.q_busy     = (state_q != S_IDLE);
  assign bus.q_f_done   = in_resp & (owner_q == OWN_F);
  assign bus.q_d_done   = in_resp & (owner_q == OWN_D);
  assign bus.q_l_done   = in_resp & (owner_q == OWN_L);
  assign bus.q_err      = in_resp & oor_q;
  // Read data is presented in the RESP cycle straight from the memory's
  // registered output, then held until the owner's next response.
  assign bus.q_f_rdata  = bus.q_f_done ? rd_val : f_rdata_q;
  assign bus.q_d_rdata  = bus.q_d_done ? rd_val : d_rdata_q;

endmodule

// File: tb/tb_prco_lmem_arbiter.sv
module tb_prco_lmem_arbiter;

  localparam logic [2:0] OF = 3'b001, OD = 3'b010, OL = 3'b100;

  typedef struct {
    int          cyc;
    logic [2:0]  own;
    logic [15:0] rd;
    logic        err;
  } done_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [15:0] addr;
    logic [15:0] dina;
    logic        chkd;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   base;

  logic        pre_we = 1'b0;
  logic [7:0]  pre_a  = '0;
  logic [15:0] pre_d  = '0;
  logic [15:0] mem [0:255];

  done_t dq[$];
  acc_t  aq[$];

  prco_lmem_arbiter_if #(.P_ADDR_W(16)) bus ();

  prco_lmem_arbiter #(.P_LMEM_DEPTH(256), .P_ADDR_W(16)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: registered read one cycle after the strobe; preload port
  // used only while the arbiter is idle.
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (bus.q_mem_ce) begin
      if (bus.q_mem_we) mem[bus.q_mem_addr[7:0]] <= bus.q_mem_dina;
      else bus.i_mem_douta <= mem[bus.q_mem_addr[7:0]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic exp_done(input int c, input logic [2:0] own, input logic [15:0] rd, input logic err);
    done_t e;
    e.cyc = c; e.own = own; e.rd = rd; e.err = err;
    dq.push_back(e);
  endtask

  task automatic exp_acc(input int c, input logic we, input logic [15:0] a, input logic [15:0] d,
                         input logic chkd);
    acc_t e;
    e.cyc = c; e.we = we; e.addr = a; e.dina = d; e.chkd = chkd;
    aq.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows a done or a strobe.
  always @(negedge clk) begin
    done_t      e;
    acc_t       a;
    logic [2:0] own;
    own = {bus.q_l_done, bus.q_d_done, bus.q_f_done};
    if (own != 3'b000) begin
      if (dq.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_unexpected cyc=%0d actual=%b required=none", cyc, own);
      end else begin
        e = dq.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_owner", {29'd0, own}, {29'd0, e.own});
        if (e.own == OF) chk("f_rdata", {16'd0, bus.q_f_rdata}, {16'd0, e.rd});
        if (e.own == OD) chk("d_rdata", {16'd0, bus.q_d_rdata}, {16'd0, e.rd});
        chk("err", {31'd0, bus.q_err}, {31'd0, e.err});
      end
    end
    if (bus.q_mem_ce) begin
      if (aq.size() == 0) begin
        checks++; failures++;
        $display("FAIL mem_ce_unexpected cyc=%0d actual_addr=0x%0h required=none", cyc, bus.q_mem_addr);
      end else begin
        a = aq.pop_front();
        chk("acc_cycle", cyc, a.cyc);
        chk("acc_we", {31'd0, bus.q_mem_we}, {31'd0, a.we});
        chk("acc_addr", {16'd0, bus.q_mem_addr}, {16'd0, a.addr});
        if (a.chkd) chk("acc_dina", {16'd0, bus.q_mem_dina}, {16'd0, a.dina});
      end
    end
  end

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((dq.size() + aq.size()) != 0 && n < 20) begin
      nclk();
      n++;
    end
    chk(nm, dq.size() + aq.size(), 0);
    dq.delete();
    aq.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ce"},      {31'd0, bus.q_mem_ce}, 0);
    chk({nm, "_we"},      {31'd0, bus.q_mem_we}, 0);
    chk({nm, "_addr"},    {16'd0, bus.q_mem_addr}, 0);
    chk({nm, "_dina"},    {16'd0, bus.q_mem_dina}, 0);
    chk({nm, "_busy"},    {31'd0, bus.q_busy}, 0);
    chk({nm, "_err"},     {31'd0, bus.q_err}, 0);
    chk({nm, "_dones"},   {29'd0, bus.q_l_done, bus.q_d_done, bus.q_f_done}, 0);
    chk({nm, "_f_rdata"}, {16'd0, bus.q_f_rdata}, 0);
    chk({nm, "_d_rdata"}, {16'd0, bus.q_d_rdata}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    bus.i_f_req = 0; bus.i_f_addr = '0;
    bus.i_d_req = 0; bus.i_d_we = 0; bus.i_d_addr = '0; bus.i_d_wdata = '0;
    bus.i_l_req = 0; bus.i_l_addr = '0; bus.i_l_wdata = '0;
    bus.i_mem_douta = '0;

    // Reset with memory preload
    nclk();
    pre_we = 1; pre_a = 8'h03; pre_d = 16'h2001; nclk();
    pre_a = 8'h10; pre_d = 16'h1234; nclk();
    pre_we = 0; nclk();
    chk_zero("reset");
    rst = 0;
    nclk();

    // Single F read
    base = cyc;
    bus.i_f_req = 1; bus.i_f_addr = 16'h0003;
    exp_acc(base + 1, 1'b0, 16'h0003, 16'h0000, 1'b0);
    exp_done(base + 2, OF, 16'h2001, 1'b0);
    repeat (2) nclk();
    bus.i_f_req = 0;
    nclk();
    chk("f_read_idle_busy", {31'd0, bus.q_busy}, 0);
    drain("f_read_drain");

    // D store then F read-back
    base = cyc;
    bus.i_d_req = 1; bus.i_d_we = 1; bus.i_d_addr = 16'h00AA; bus.i_d_wdata = 16'hCAFE;
    exp_acc(base + 1, 1'b1, 16'h00AA, 16'hCAFE, 1'b1);
    exp_done(base + 2, OD, 16'h0000, 1'b0);
    repeat (2) nclk();
    bus.i_d_req = 0; bus.i_d_we = 0;
    nclk();
    base = cyc;
    bus.i_f_req = 1; bus.i_f_addr = 16'h00AA;
    exp_acc(base + 1, 1'b0, 16'h00AA, 16'h0000, 1'b0);
    exp_done(base + 2, OF, 16'hCAFE, 1'b0);
    repeat (2) nclk();
    bus.i_f_req = 0;
    nclk();
    drain("store_load_drain");

    // F/D contention from reset: F first, then alternate
    rst = 1; nclk(); rst = 0; nclk();
    base = cyc;
    bus.i_f_req = 1; bus.i_f_addr = 16'h0003;
    bus.i_d_req = 1; bus.i_d_we = 0; bus.i_d_addr = 16'h0010;
    for (int k = 0; k < 2; k++) begin
      exp_acc(base + 1 + 4 * k, 1'b0, 16'h0003, 16'h0000, 1'b0);
      exp_done(base + 2 + 4 * k, OF, 16'h2001, 1'b0);
      exp_acc(base + 3 + 4 * k, 1'b0, 16'h0010, 16'h0000, 1'b0);
      exp_done(base + 4 + 4 * k, OD, 16'h1234, 1'b0);
    end
    repeat (8) nclk();
    bus.i_f_req = 0; bus.i_d_req = 0;
    nclk();
    chk("contend_idle_busy", {31'd0, bus.q_busy}, 0);
    drain("contend_drain");

    // L, F, D together: L first and again while it persists; F/D resume
    base = cyc;
    bus.i_l_req = 1; bus.i_l_addr = 16'h0020; bus.i_l_wdata = 16'h5A5A;
    bus.i_f_req = 1; bus.i_f_addr = 16'h0003;
    bus.i_d_req = 1; bus.i_d_we = 0; bus.i_d_addr = 16'h0010;
    exp_acc(base + 1,  1'b1, 16'h0020, 16'h5A5A, 1'b1);
    exp_done(base + 2,  OL, 16'h0000, 1'b0);
    exp_acc(base + 3,  1'b0, 16'h0003, 16'h0000, 1'b0);
    exp_done(base + 4,  OF, 16'h2001, 1'b0);
    exp_acc(base + 5,  1'b1, 16'h0021, 16'h6B6B, 1'b1);
    exp_done(base + 6,  OL, 16'h0000, 1'b0);
    exp_acc(base + 7,  1'b0, 16'h0010, 16'h0000, 1'b0);
    exp_done(base + 8,  OD, 16'h1234, 1'b0);
    exp_acc(base + 9,  1'b0, 16'h0003, 16'h0000, 1'b0);
    exp_done(base + 10, OF, 16'h2001, 1'b0);
    exp_acc(base + 11, 1'b0, 16'h0010, 16'h0000, 1'b0);
    exp_done(base + 12, OD, 16'h1234, 1'b0);
    repeat (2) nclk();
    bus.i_l_addr = 16'h0021; bus.i_l_wdata = 16'h6B6B;
    repeat (4) nclk();
    bus.i_l_req = 0;
    repeat (6) nclk();
    bus.i_f_req = 0; bus.i_d_req = 0;
    nclk();
    drain("three_way_drain");
    base = cyc;
    bus.i_f_req = 1; bus.i_f_addr = 16'h0021;
    exp_acc(base + 1, 1'b0, 16'h0021, 16'h0000, 1'b0);
    exp_done(base + 2, OF, 16'h6B6B, 1'b0);
    repeat (2) nclk();
    bus.i_f_req = 0;
    nclk();
    drain("loader_readback_drain");

    // Out-of-range D load: no strobe, done+err one cycle after grant
    base = cyc;
    bus.i_d_req = 1; bus.i_d_we = 0; bus.i_d_addr = 16'h0100;
    exp_done(base + 1, OD, 16'h0000, 1'b1);
    nclk();
    bus.i_d_req = 0;
    chk("oor_addr_hold", {16'd0, bus.q_mem_addr}, 32'h0021);
    nclk();
    chk("oor_idle_busy", {31'd0, bus.q_busy}, 0);
    drain("oor_drain");

    // Reset during ACCESS: outputs clear at once, no done; then normal service
    base = cyc;
    bus.i_f_req = 1; bus.i_f_addr = 16'h0003;
    exp_acc(base + 1, 1'b0, 16'h0003, 16'h0000, 1'b0);
    nclk();
    #1 rst = 1;
    #1 chk_zero("midreset");
    nclk();
    rst = 0;
    base = cyc;
    exp_acc(base + 1, 1'b0, 16'h0003, 16'h0000, 1'b0);
    exp_done(base + 2, OF, 16'h2001, 1'b0);
    repeat (2) nclk();
    bus.i_f_req = 0;
    nclk();
    drain("post_reset_drain");

    repeat (3) nclk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prco_lmem_arbiter.md
Name: prco_lmem_arbiter

Overview:
- Single-port arbiter and sequencer for the on-chip local memory (16-bit words, 1-cycle synchronous read).
- Shares the memory between three requesters:
  - instruction fetch (F), read-only;
  - ALU load/store data port (D), read/write;
  - UART boot loader (L), write-only.
- Issues one access at a time and returns read data with a done pulse.
- Sits between the core pipeline/loader and the local memory, replacing direct pipeline strobes into memory.

Parameters:
- P_LMEM_DEPTH, 256, number of valid memory words; word addresses >= P_LMEM_DEPTH are out of range.
- P_ADDR_W, 16, address width of all address ports.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_reset  input  1  reset, asynchronous, active-high.
- i_f_req  input  1  fetch request; held until q_f_done.
- i_f_addr  input  P_ADDR_W  fetch word address.
- q_f_done  output  1  one-cycle completion pulse, fetch.
- q_f_rdata  output  16  fetch read data; valid while q_f_done=1.
- i_d_req  input  1  data request; held until q_d_done.
- i_d_we  input  1  data write enable (1=store, 0=load).
- i_d_addr  input  P_ADDR_W  data word address.
- i_d_wdata  input  16  store data.
- q_d_done  output  1  one-cycle completion pulse, data.
- q_d_rdata  output  16  load data; valid while q_d_done=1.
- i_l_req  input  1  loader write request; held until q_l_done.
- i_l_addr  input  P_ADDR_W  loader word address.
- i_l_wdata  input  16  loader write data.
- q_l_done  output  1  one-cycle completion pulse, loader.
- q_err  output  1  pulses with done when the completed request was out of range.
- q_busy  output  1  high in ACCESS and RESP states.
- q_mem_ce  output  1  memory access strobe.
- q_mem_we  output  1  memory write enable.
- q_mem_addr  output  P_ADDR_W  memory address.
- q_mem_dina  output  16  memory write data.
- i_mem_douta  input  16  memory read data, registered by memory one cycle after q_mem_ce.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE;
  - all q_* outputs 0;
  - latched owner/addr/data/we cleared;
  - round-robin pointer rr_last=D, so F wins the first F/D tie.
- Reset mid-access abandons the access. No done pulse is issued. A memory write strobed in the same edge may or may not land; benches must not check it.
- States: IDLE, ACCESS, RESP.
- Arbitration is evaluated at the edge ending IDLE or RESP:
  - L has fixed highest priority.
  - Otherwise F vs D round-robin: with both requesting, grant the one not equal to rr_last. With one requesting, grant it.
  - rr_last updates on every F or D grant. L grants do not change rr_last.
- In RESP, the current owner's req is masked, because it is still high during its done cycle.
- On grant, latch owner, addr, wdata and we (F: we=0; L: we=1) and go to ACCESS.
- Out-of-range grant (addr >= P_LMEM_DEPTH): go directly to RESP without strobing memory. The response has rdata=0 and q_err=1.
- ACCESS (1 cycle):
  - q_mem_ce=1, q_mem_we=latched we;
  - q_mem_addr and q_mem_dina from latches;
  - next state RESP.
- Outside ACCESS: q_mem_ce=0 and q_mem_we=0. q_mem_addr and q_mem_dina hold their last values.
- RESP (1 cycle):
  - owner's q_x_done=1;
  - q_f_rdata/q_d_rdata = i_mem_douta for reads, 0 for writes;
  - q_err=1 only for an out-of-range request.
  - Next state: ACCESS if another grant is made at this edge, else IDLE.
- Latency: req high at edge N in IDLE gives ACCESS in cycle N+1 and done in cycle N+2. Back-to-back sustained throughput is one access per 2 cycles.
- rdata outputs are registered, updated only in the owner's RESP cycle, and otherwise hold their value. done and err are single-cycle pulses.
- A requester dropping req before done: the request was already latched, so the access completes and done still pulses.
- Address wrap: no wrap. Out-of-range addresses are never forwarded to memory.

Test Plan:
- Single F read: memory preloaded [0x0003]=0x2001; F req addr 0x0003 at edge 0 → q_mem_ce in cycle 1 with addr 0x0003, we=0 → q_f_done=1 and q_f_rdata=0x2001 in cycle 2 → IDLE in cycle 3.
- D store then F read: D we=1 addr 0x00AA data 0xCAFE → memory write in ACCESS with q_d_done and q_d_rdata=0 in RESP; then F read of 0x00AA returns 0xCAFE.
- F and D contend continuously from reset: grant order F, D, F, D; dones spaced 2 cycles apart; no done for a requester whose req was masked.
- L, F and D all requesting: L granted first and granted again while i_l_req persists; after L drops, F/D resume alternation from the prior rr_last.
- Out-of-range: D load at addr 0x0100 (P_LMEM_DEPTH=256) → q_mem_ce never asserted; q_d_done=1, q_err=1, q_d_rdata=0 one cycle after grant.
- Assert i_reset during ACCESS → all outputs 0 immediately; no done pulse; after release, a pending F req is served with normal 2-cycle latency.
